// File: rtl/cp0_ext_if.sv
// Bus between the M/W pipeline stages and coprocessor 0. The pipeline drives
// the master side; cp0_ext implements the slave side.
`timescale 1ns/1ps
interface cp0_ext_if #(
  parameter int unsigned NUM_HWINT = 5
);
  logic [NUM_HWINT-1:0] hw_int;
  logic                 exc_valid;
  logic [4:0]           exc_code;
  logic [31:0]          victim_pc;
  logic                 victim_bd;
  logic                 eret;
  logic                 mtc0_we;
  logic [4:0]           wr_addr;
  logic [31:0]          wdata;
  logic [4:0]           rd_addr;
  logic [31:0]          rdata;
  logic                 int_req;
  logic                 exc_take;
  logic [31:0]          handler_pc;
  logic [31:0]          epc;

  modport master (
    output hw_int, exc_valid, exc_code, victim_pc, victim_bd, eret,
           mtc0_we, wr_addr, wdata, rd_addr,
    input  rdata, int_req, exc_take, handler_pc, epc
  );

  modport slave (
    input  hw_int, exc_valid, exc_code, victim_pc, victim_bd, eret,
           mtc0_we, wr_addr, wdata, rd_addr,
    output rdata, int_req, exc_take, handler_pc, epc
  );
endinterface

// File: rtl/cp0_ext.sv
// Coprocessor 0: SR, Cause, EPC, PRId, Count and Compare, with interrupt
// arbitration and a combinational exception-take strobe for the flush unit.
`timescale 1ns/1ps
module cp0_ext #(
  parameter int unsigned NUM_HWINT  = 5,
  parameter int unsigned TIMER_DIV  = 1,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h0000_0001
) (
  input  logic     clk_i,
  input  logic     reset_n_i,
  cp0_ext_if.slave bus
);

  localparam logic [7:0] PRESC_MAX = 8'(TIMER_DIV - 1);
  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_SR      = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_PRID    = 5'd15;

  function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  ip_hw_q, ip_hw_d;
  logic        ip_timer_q, ip_timer_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  presc_q, presc_d;

  logic [4:0]  hw_pad_s;
  logic [7:0]  ip_s;
  logic        int_req_s;
  logic        exc_take_s;
  logic        presc_wrap_s;
  logic [31:0] count_inc_s;
  logic [31:0] rdata_s;

  // Zero-extend the device lines to the five Cause IP slots 10..14.
  always_comb begin
    hw_pad_s                  = 5'd0;
    hw_pad_s[NUM_HWINT-1:0]   = bus.hw_int;
  end

  assign ip_s         = {ip_timer_q, ip_hw_q, ip_sw_q};
  assign int_req_s    = (|(ip_s & im_q)) & ie_q & ~exl_q;
  assign exc_take_s   = bus.exc_valid | int_req_s;
  assign presc_wrap_s = (presc_q == PRESC_MAX);
  assign count_inc_s  = count_q + 32'd1;

  // Next-state: timer runs every cycle; then take > eret > mtc0.
  always_comb begin
    count_d    = count_q;
    compare_d  = compare_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = hw_pad_s;
    ip_timer_d = ip_timer_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    presc_d    = presc_q;

    if (presc_wrap_s) begin
      presc_d = 8'd0;
      count_d = count_inc_s;
      if (count_inc_s == compare_q) begin
        ip_timer_d = 1'b1;
      end else begin
        ip_timer_d = ip_timer_q;
      end
    end else begin
      presc_d = presc_q + 8'd1;
    end

    if (exc_take_s) begin
      // A nested exception keeps the original return point.
      if (!exl_q) begin
        epc_d = victim_epc(bus.victim_pc, bus.victim_bd);
        bd_d  = bus.victim_bd;
      end else begin
        epc_d = epc_q;
        bd_d  = bd_q;
      end
      exl_d      = 1'b1;
      exc_code_d = bus.exc_valid ? bus.exc_code : 5'd0;
    end else if (bus.eret) begin
      exl_d = 1'b0;
    end else if (bus.mtc0_we) begin
      case (bus.wr_addr)
        A_COUNT: begin
          count_d    = bus.wdata;
          presc_d    = 8'd0;
          ip_timer_d = ip_timer_q;
        end
        A_COMPARE: begin
          compare_d  = bus.wdata;
          ip_timer_d = 1'b0;
        end
        A_SR: begin
          im_d  = bus.wdata[15:8];
          exl_d = bus.wdata[1];
          ie_d  = bus.wdata[0];
        end
        A_CAUSE: ip_sw_d = bus.wdata[9:8];
        A_EPC:   epc_d   = bus.wdata;
        default: ;
      endcase
    end else begin
      exl_d = exl_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q    <= 32'd0;
      compare_q  <= 32'hFFFF_FFFF;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_sw_q    <= 2'd0;
      ip_hw_q    <= 5'd0;
      ip_timer_q <= 1'b0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
      presc_q    <= 8'd0;
    end else begin
      count_q    <= count_d;
      compare_q  <= compare_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      ip_timer_q <= ip_timer_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      presc_q    <= presc_d;
    end
  end

  // mfc0 read mux.
  always_comb begin
    rdata_s = 32'd0;
    case (bus.rd_addr)
      A_COUNT:   rdata_s = count_q;
      A_COMPARE: rdata_s = compare_q;
      A_SR:      rdata_s = {16'd0, im_q, 6'd0, exl_q, ie_q};
      A_CAUSE:   rdata_s = {bd_q, 15'd0, ip_s, 1'b0, exc_code_q, 2'b00};
      A_EPC:     rdata_s = epc_q;
      A_PRID:    rdata_s = PRID;
      default:   rdata_s = 32'd0;
    endcase
  end

  assign bus.rdata      = rdata_s;
  assign bus.int_req    = int_req_s;
  assign bus.exc_take   = exc_take_s;
  assign bus.handler_pc = EXC_VECTOR;
  assign bus.epc        = epc_q;

endmodule

// File: tb/tb_cp0_ext.sv
// Directed bench for cp0_ext: reset values, register map, interrupts,
// exceptions, priority, timer and asynchronous reset.
`timescale 1ns/1ps
module tb_cp0_ext;
  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  cp0_ext_if #(.NUM_HWINT(5)) bus ();

  cp0_ext #(
    .NUM_HWINT (5),
    .TIMER_DIV (4),
    .EXC_VECTOR(32'h0000_4180),
    .PRID      (32'h0000_0001)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.mtc0_we = 1'b1;
    bus.wr_addr = addr;
    bus.wdata   = data;
    tick();
    bus.mtc0_we = 1'b0;
    bus.wr_addr = 5'd0;
    bus.wdata   = 32'd0;
  endtask

  task automatic do_eret();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_tab [6];
    logic [4:0]  adr_tab [6];
    exp_tab = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h1};
    adr_tab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.rd_addr = adr_tab[i];
      #1;
      n_tests++;
      if (bus.rdata !== exp_tab[i]) begin
        n_fail++;
        $display("FAIL reset_reg%0d got %h exp %h", adr_tab[i], bus.rdata, exp_tab[i]);
      end
    end
    n_tests++;
    if (bus.int_req !== 1'b0 || bus.exc_take !== 1'b0 || bus.epc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outs got int_req=%b take=%b epc=%h exp 0 0 0",
               bus.int_req, bus.exc_take, bus.epc);
    end
    n_tests++;
    if (bus.handler_pc !== 32'h0000_4180) begin
      n_fail++;
      $display("FAIL handler_pc got %h exp %h", bus.handler_pc, 32'h0000_4180);
    end
  endtask

  task automatic test_regs();
    do_mtc0(5'd14, 32'hDEAD_BEE0);
    bus.rd_addr = 5'd14; #1;
    n_tests++;
    if (bus.rdata !== 32'hDEAD_BEE0 || bus.epc !== 32'hDEAD_BEE0) begin
      n_fail++;
      $display("FAIL epc_write got rdata=%h epc=%h exp %h", bus.rdata, bus.epc, 32'hDEAD_BEE0);
    end
    do_mtc0(5'd15, 32'h0000_1234);
    bus.rd_addr = 5'd15; #1;
    n_tests++;
    if (bus.rdata !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL prid_ro got %h exp %h", bus.rdata, 32'h1);
    end
    do_mtc0(5'd3, 32'hFFFF_FFFF);
    bus.rd_addr = 5'd3; #1;
    n_tests++;
    if (bus.rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped got %h exp %h", bus.rdata, 32'h0);
    end
    do_mtc0(5'd12, 32'hFFFF_FFFF);
    bus.rd_addr = 5'd12; #1;
    n_tests++;
    if (bus.rdata !== 32'h0000_FF03) begin
      n_fail++;
      $display("FAIL sr_mask got %h exp %h", bus.rdata, 32'h0000_FF03);
    end
    do_mtc0(5'd13, 32'hFFFF_FFFF);
    bus.rd_addr = 5'd13; #1;
    n_tests++;
    if (bus.rdata !== 32'h0000_0300) begin
      n_fail++;
      $display("FAIL cause_mask got %h exp %h", bus.rdata, 32'h0000_0300);
    end
    do_mtc0(5'd13, 32'h0);
    do_mtc0(5'd12, 32'h0);
  endtask

  task automatic test_hw_int();
    do_mtc0(5'd12, 32'h0000_0401);
    bus.hw_int    = 5'b00001;
    bus.victim_pc = 32'h0000_3000;
    bus.victim_bd = 1'b0;
    #1;
    n_tests++;
    if (bus.int_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hw_latency got int_req=%b exp 0", bus.int_req);
    end
    tick();
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.exc_take !== 1'b1) begin
      n_fail++;
      $display("FAIL hw_req got int_req=%b take=%b exp 1 1", bus.int_req, bus.exc_take);
    end
    tick();
    n_tests++;
    if (bus.epc !== 32'h0000_3000 || bus.int_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hw_entry got epc=%h int_req=%b exp %h 0", bus.epc, bus.int_req, 32'h3000);
    end
    bus.rd_addr = 5'd12; #1;
    n_tests++;
    if (bus.rdata !== 32'h0000_0403) begin
      n_fail++;
      $display("FAIL hw_sr got %h exp %h", bus.rdata, 32'h0000_0403);
    end
    bus.rd_addr = 5'd13; #1;
    n_tests++;
    if (bus.rdata !== 32'h0000_0400) begin
      n_fail++;
      $display("FAIL hw_cause got %h exp %h", bus.rdata, 32'h0000_0400);
    end
    bus.hw_int = 5'b00000;
    do_eret();
    n_tests++;
    if (bus.int_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hw_eret got int_req=%b exp 0", bus.int_req);
    end
    do_mtc0(5'd12, 32'h0);
  endtask

  task automatic test_exc_bd();
    bus.exc_valid = 1'b1;
    bus.exc_code  = 5'd10;
    bus.victim_pc = 32'h0000_3010;
    bus.victim_bd = 1'b1;
    #1;
    n_tests++;
    if (bus.exc_take !== 1'b1) begin
      n_fail++;
      $display("FAIL exc_take got %b exp 1", bus.exc_take);
    end
    tick();
    bus.rd_addr = 5'd13; #1;
    n_tests++;
    if (bus.epc !== 32'h0000_300C || bus.rdata !== 32'h8000_0028) begin
      n_fail++;
      $display("FAIL exc_bd got epc=%h cause=%h exp %h %h", bus.epc, bus.rdata,
               32'h0000_300C, 32'h8000_0028);
    end
    bus.exc_code  = 5'd4;
    bus.victim_pc = 32'h0000_5000;
    bus.victim_bd = 1'b0;
    tick();
    bus.exc_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.epc !== 32'h0000_300C || bus.rdata !== 32'h8000_0010) begin
      n_fail++;
      $display("FAIL exc_nested got epc=%h cause=%h exp %h %h", bus.epc, bus.rdata,
               32'h0000_300C, 32'h8000_0010);
    end
    do_eret();
  endtask

  task automatic test_priority();
    do_mtc0(5'd12, 32'h0000_AB00);
    bus.exc_valid = 1'b1;
    bus.exc_code  = 5'd12;
    bus.victim_pc = 32'h0000_4000;
    bus.victim_bd = 1'b0;
    bus.eret      = 1'b1;
    do_mtc0(5'd12, 32'h0000_0001);
    bus.exc_valid = 1'b0;
    bus.eret      = 1'b0;
    bus.rd_addr   = 5'd12; #1;
    n_tests++;
    if (bus.rdata !== 32'h0000_AB02) begin
      n_fail++;
      $display("FAIL prio_sr got %h exp %h", bus.rdata, 32'h0000_AB02);
    end
    bus.rd_addr = 5'd13; #1;
    n_tests++;
    if (bus.rdata !== 32'h0000_0030 || bus.epc !== 32'h0000_4000) begin
      n_fail++;
      $display("FAIL prio_cause got cause=%h epc=%h exp %h %h", bus.rdata, bus.epc,
               32'h30, 32'h4000);
    end
    bus.eret = 1'b1;
    do_mtc0(5'd14, 32'h0000_1234);
    bus.eret    = 1'b0;
    bus.rd_addr = 5'd12; #1;
    n_tests++;
    if (bus.rdata !== 32'h0000_AB00 || bus.epc !== 32'h0000_4000) begin
      n_fail++;
      $display("FAIL eret_over_mtc0 got sr=%h epc=%h exp %h %h", bus.rdata, bus.epc,
               32'hAB00, 32'h4000);
    end
    do_mtc0(5'd12, 32'h0);
  endtask

  task automatic test_sw_int();
    do_mtc0(5'd13, 32'h0000_0300);
    bus.rd_addr = 5'd13; #1;
    n_tests++;
    if (bus.rdata !== 32'h0000_0330) begin
      n_fail++;
      $display("FAIL sw_cause got %h exp %h", bus.rdata, 32'h0000_0330);
    end
    bus.victim_pc = 32'h0000_6000;
    bus.victim_bd = 1'b0;
    bus.mtc0_we   = 1'b1;
    bus.wr_addr   = 5'd12;
    bus.wdata     = 32'h0000_0201;
    #1;
    n_tests++;
    if (bus.int_req !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_early got int_req=%b exp 0", bus.int_req);
    end
    tick();
    bus.mtc0_we = 1'b0;
    #1;
    n_tests++;
    if (bus.int_req !== 1'b1 || bus.exc_take !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_req got int_req=%b take=%b exp 1 1", bus.int_req, bus.exc_take);
    end
    tick();
    n_tests++;
    if (bus.int_req !== 1'b0 || bus.epc !== 32'h0000_6000 || bus.rdata !== 32'h0000_0300) begin
      n_fail++;
      $display("FAIL sw_entry got int_req=%b epc=%h cause=%h exp 0 %h %h", bus.int_req,
               bus.epc, bus.rdata, 32'h6000, 32'h300);
    end
    do_eret();
    n_tests++;
    if (bus.int_req !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_eret got int_req=%b exp 1", bus.int_req);
    end
    tick();
    do_mtc0(5'd12, 32'h0);
    do_mtc0(5'd13, 32'h0);
  endtask

  task automatic test_timer();
    bus.victim_pc = 32'h0000_7000;
    bus.victim_bd = 1'b0;
    do_mtc0(5'd11, 32'h0000_0003);
    do_mtc0(5'd9, 32'h0);
    do_mtc0(5'd12, 32'h0000_8001);
    repeat (10) tick();
    bus.rd_addr = 5'd9; #1;
    n_tests++;
    if (bus.rdata !== 32'd2 || bus.int_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timer_pre got count=%0d int_req=%b exp 2 0", bus.rdata, bus.int_req);
    end
    tick();
    n_tests++;
    if (bus.rdata !== 32'd3 || bus.int_req !== 1'b1) begin
      n_fail++;
      $display("FAIL timer_hit got count=%0d int_req=%b exp 3 1", bus.rdata, bus.int_req);
    end
    bus.rd_addr = 5'd13; #1;
    n_tests++;
    if (bus.rdata !== 32'h0000_8000) begin
      n_fail++;
      $display("FAIL timer_ip got %h exp %h", bus.rdata, 32'h0000_8000);
    end
    tick();
    n_tests++;
    if (bus.int_req !== 1'b0 || bus.epc !== 32'h0000_7000) begin
      n_fail++;
      $display("FAIL timer_take got int_req=%b epc=%h exp 0 %h", bus.int_req, bus.epc, 32'h7000);
    end
    do_mtc0(5'd11, 32'h0000_0100);
    bus.rd_addr = 5'd13; #1;
    n_tests++;
    if (bus.rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL timer_clear got %h exp %h", bus.rdata, 32'h0);
    end
    do_mtc0(5'd12, 32'h0);
  endtask

  task automatic test_async_reset();
    do_mtc0(5'd12, 32'h0000_0401);
    bus.hw_int = 5'b00001;
    tick();
    n_tests++;
    if (bus.int_req !== 1'b1) begin
      n_fail++;
      $display("FAIL ares_pre got int_req=%b exp 1", bus.int_req);
    end
    #10;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.int_req !== 1'b0 || bus.exc_take !== 1'b0 || bus.epc !== 32'h0) begin
      n_fail++;
      $display("FAIL ares got int_req=%b take=%b epc=%h exp 0 0 0", bus.int_req,
               bus.exc_take, bus.epc);
    end
    bus.hw_int = 5'b00000;
    tick();
    reset_n = 1'b1;
    bus.rd_addr = 5'd11; #1;
    n_tests++;
    if (bus.rdata !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL ares_compare got %h exp %h", bus.rdata, 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    bus.hw_int    = 5'd0;
    bus.exc_valid = 1'b0;
    bus.exc_code  = 5'd0;
    bus.victim_pc = 32'd0;
    bus.victim_bd = 1'b0;
    bus.eret      = 1'b0;
    bus.mtc0_we   = 1'b0;
    bus.wr_addr   = 5'd0;
    bus.wdata     = 32'd0;
    bus.rd_addr   = 5'd0;
    test_reset();
    test_regs();
    test_hw_int();
    test_exc_bd();
    test_priority();
    test_sw_int();
    test_timer();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
